vote_tally_engine: RTL and testbench
====================================

Name: vote_tally_engine

Overview:
- Parametrised successor to the fixed 4-candidate voting machine.
- Supports N candidates, configurable tally width, hold threshold and feedback duration.
- Adds per-session arming (one vote per voter), multi-press rejection, saturating tallies, indexed view mode and registered leader/tie detection.
- Sits between raw candidate buttons plus a poll-worker "session_start" control and the LED display.

Parameters:
- NUM_CAND, 4, number of candidates (2..16).
- CNT_W, 8, tally width per candidate and LED width.
- HOLD_CYCLES, 10, consecutive sampled-high cycles required for a valid press (>=2).
- FLASH_CYCLES, 10, cycles LEDs show all-ones after an accepted vote (>=1).
- IDX_W, $clog2(NUM_CAND), candidate index width (derived, not overridable).

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high; clears all state and tallies.
- mode  in  1  0 = vote mode, 1 = view mode.
- session_start  in  1  one-cycle pulse arming the machine for exactly one vote.
- button  in  NUM_CAND  candidate buttons, bit i = candidate i, assumed synchronised.
- view_sel  in  IDX_W  candidate shown in view mode.
- led  out  CNT_W  display output.
- ready  out  1  high while armed and waiting for a press.
- vote_accepted  out  1  one-cycle pulse when a vote is committed.
- vote_cand  out  IDX_W  index of the committed candidate, valid with vote_accepted.
- leader  out  IDX_W  index of the highest tally.
- leader_valid  out  1  0 when the top tally is tied (including all-zero).
- sat  out  NUM_CAND  bit i sticky-high once tally i has saturated.

Behaviour:
- Reset values: state IDLE, all tallies 0, led 0, ready 0, vote_accepted 0, vote_cand 0, leader 0, leader_valid 0, sat 0, hold and flash counters 0.
- FSM states: IDLE, ARMED, HOLD, COMMIT, FLASH, RELEASE.
- IDLE: if session_start && mode==0, go to ARMED. session_start in any other state is ignored.
- ARMED (ready=1):
  - Exactly one button bit high: capture its index, hold_cnt=1, go to HOLD.
  - Zero or more than one bit high: stay in ARMED.
- HOLD:
  - button == one-hot of the captured index: hold_cnt++.
  - When hold_cnt==HOLD_CYCLES-1 and the press is still present, go to COMMIT.
  - Any other button pattern (release or extra button): return to ARMED, hold_cnt=0. The session is not consumed.
- COMMIT (one cycle):
  - vote_accepted=1 and vote_cand=captured index.
  - tally[idx] increments, saturating at 2^CNT_W-1.
  - If the tally was already at max, it stays at max and sat[idx] is set; vote_accepted still pulses.
  - flash_cnt=0, then go to FLASH.
- FLASH: led=all-ones. Lasts FLASH_CYCLES cycles, then go to RELEASE.
- RELEASE: wait until button==0, then go to IDLE. Buttons held across the session end never carry a vote into the next session.
- Timing: a button sampled high on HOLD_CYCLES consecutive edges starting in ARMED gives COMMIT in the following cycle. The new tally is visible one cycle after COMMIT.
- mode==1 in any state except COMMIT forces IDLE on the next edge and abandons the session. COMMIT always completes.
- led:
  - Vote mode: 0 outside FLASH.
  - View mode: registered tally[view_sel], one-cycle latency.
  - view_sel >= NUM_CAND shows 0.
- Leader: registered each cycle from the current tallies.
  - leader = lowest index holding the maximum tally.
  - leader_valid = 0 if two or more candidates share that maximum.
  - Leader outputs lag a tally update by one cycle.
- sat bits clear only on reset.

Decomposition:
- Package vote_pkg holds:
  - the state enum (IDLE, ARMED, HOLD, COMMIT, FLASH, RELEASE);
  - the one-hot check function;
  - the IDX_W derivation helper.
- One natural sub-module: vote_leader_tree, a parametrised registered argmax with tie flag over NUM_CAND x CNT_W tallies.
- The FSM, tallies and LED mux stay in the top level.

Test Plan:
- Reset, session_start, then button=4'b0010 held 10 cycles: exactly one vote_accepted with vote_cand=1; tally1=1; led=FF for 10 cycles; ready=0 afterwards.
- Press held only 9 cycles, then released: no vote, ready stays 1. Re-press for 10 cycles: tally incremented once.
- button=4'b0011 for 20 cycles while armed: no vote. Second button dropped to give 4'b0001 for 10 cycles: vote for candidate 0.
- Without a new session_start, button=4'b0100 held 50 cycles after a committed vote: no further increment (machine in RELEASE, then IDLE).
- CNT_W=8, 256 sessions voting candidate 2: tally2=255, sat[2]=1, vote_accepted pulsed 256 times.
- View mode checks:
  - Tallies {3,5,5,1}: leader=1, leader_valid=0.
  - One more vote for candidate 2: leader=2, leader_valid=1 one cycle after the update.
  - view_sel=2 gives led=6.
  - mode=1 asserted during HOLD gives IDLE and no vote.

Source files
------------

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared state type and helpers for the vote tally engine
package vote_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        HOLD,
        COMMIT,
        FLASH,
        RELEASE
    } state_t;

    // Widest candidate vector the engine supports.
    localparam int MAX_CAND = 16;

    // Index width for n candidates; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // True when exactly one bit of the (zero-extended) button vector is set.
    function automatic logic is_one_hot(input logic [MAX_CAND-1:0] v);
        return ($countones(v) == 1);
    endfunction

endpackage

// File: rtl/vote_leader_tree.sv
// rtl/vote_leader_tree.sv - registered argmax with tie flag over all tallies
module vote_leader_tree
    import vote_pkg::*;
#(
    parameter int NUM_CAND = 4,
    parameter int CNT_W    = 8,
    localparam int IDX_W   = idx_width(NUM_CAND)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_CAND*CNT_W-1:0] tallies,
    output logic [IDX_W-1:0]          leader,
    output logic                      leader_valid
);

    logic [CNT_W-1:0] best;
    logic [IDX_W-1:0] best_idx;
    logic             tie;

    // Priority scan: strict greater-than keeps the lowest index among equals,
    // and any later equal value marks the current maximum as shared.
    always_comb begin
        best     = tallies[CNT_W-1:0];
        best_idx = '0;
        tie      = 1'b0;
        for (int i = 1; i < NUM_CAND; i++) begin
            if (tallies[i*CNT_W +: CNT_W] > best) begin
                best     = tallies[i*CNT_W +: CNT_W];
                best_idx = IDX_W'(i);
                tie      = 1'b0;
            end else if (tallies[i*CNT_W +: CNT_W] == best) begin
                tie = 1'b1;
            end
        end
    end

    // Register the result so the leader outputs trail a tally change by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            leader       <= '0;
            leader_valid <= 1'b0;
        end else begin
            leader       <= best_idx;
            leader_valid <= ~tie;
        end
    end

endmodule

// File: rtl/vote_tally_engine.sv
// rtl/vote_tally_engine.sv - armed one-vote-per-session tally engine with LED view
module vote_tally_engine
    import vote_pkg::*;
#(
    parameter int NUM_CAND     = 4,
    parameter int CNT_W        = 8,
    parameter int HOLD_CYCLES  = 10,
    parameter int FLASH_CYCLES = 10,
    localparam int IDX_W       = idx_width(NUM_CAND)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mode,
    input  logic                session_start,
    input  logic [NUM_CAND-1:0] button,
    input  logic [IDX_W-1:0]    view_sel,
    output logic [CNT_W-1:0]    led,
    output logic                ready,
    output logic                vote_accepted,
    output logic [IDX_W-1:0]    vote_cand,
    output logic [IDX_W-1:0]    leader,
    output logic                leader_valid,
    output logic [NUM_CAND-1:0] sat
);

    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                    state;
    state_t                    state_next;
    logic [IDX_W-1:0]          cand_idx;
    logic [IDX_W-1:0]          cand_next;
    logic [HOLD_W-1:0]         hold_cnt;
    logic [HOLD_W-1:0]         hold_next;
    logic [FLASH_W-1:0]        flash_cnt;
    logic [FLASH_W-1:0]        flash_next;
    logic [CNT_W-1:0]          tally [NUM_CAND];
    logic [NUM_CAND*CNT_W-1:0] tally_flat;
    logic [CNT_W-1:0]          view_q;
    logic                      view_ok;
    logic [IDX_W-1:0]          press_idx;
    logic                      press_single;
    logic                      press_match;

    // Index of the lowest pressed button; only used when exactly one is pressed.
    always_comb begin
        press_idx = '0;
        for (int i = NUM_CAND - 1; i >= 0; i--) begin
            if (button[i]) begin
                press_idx = IDX_W'(i);
            end
        end
    end

    assign press_single = is_one_hot(MAX_CAND'(button));
    assign press_match  = (button == (NUM_CAND'(1) << cand_idx));
    assign view_ok      = ({1'b0, view_sel} < (IDX_W + 1)'(NUM_CAND));

    // Session FSM: view mode abandons any session except a commit in flight.
    always_comb begin
        state_next = state;
        cand_next  = cand_idx;
        hold_next  = hold_cnt;
        flash_next = flash_cnt;
        if (mode && (state != COMMIT)) begin
            state_next = IDLE;
            hold_next  = '0;
            flash_next = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (session_start) begin
                        state_next = ARMED;
                    end
                end
                ARMED: begin
                    if (press_single) begin
                        cand_next  = press_idx;
                        hold_next  = HOLD_W'(1);
                        state_next = HOLD;
                    end
                end
                HOLD: begin
                    if (press_match) begin
                        if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
                            state_next = COMMIT;
                        end else begin
                            hold_next = hold_cnt + 1'b1;
                        end
                    end else begin
                        // Release or extra button: keep the session, restart the press.
                        hold_next  = '0;
                        state_next = ARMED;
                    end
                end
                COMMIT: begin
                    hold_next  = '0;
                    flash_next = '0;
                    state_next = FLASH;
                end
                FLASH: begin
                    if (flash_cnt == FLASH_W'(FLASH_CYCLES - 1)) begin
                        flash_next = '0;
                        state_next = RELEASE;
                    end else begin
                        flash_next = flash_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // A held button must be let go before a new session can start.
                    if (button == '0) begin
                        state_next = IDLE;
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // State, captured candidate and the hold/flash counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            cand_idx  <= '0;
            hold_cnt  <= '0;
            flash_cnt <= '0;
        end else begin
            state     <= state_next;
            cand_idx  <= cand_next;
            hold_cnt  <= hold_next;
            flash_cnt <= flash_next;
        end
    end

    // Saturating tally update on commit; a vote at full scale only flags sat.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CAND; i++) begin
                tally[i] <= '0;
            end
            sat <= '0;
        end else if (state == COMMIT) begin
            if (tally[cand_idx] == CNT_MAX) begin
                sat[cand_idx] <= 1'b1;
            end else begin
                tally[cand_idx] <= tally[cand_idx] + 1'b1;
            end
        end
    end

    // Registered view of the selected tally; out-of-range selects read as zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            view_q <= '0;
        end else begin
            view_q <= view_ok ? tally[view_sel] : '0;
        end
    end

    // Pack tallies for the leader search.
    always_comb begin
        tally_flat = '0;
        for (int i = 0; i < NUM_CAND; i++) begin
            tally_flat[i*CNT_W +: CNT_W] = tally[i];
        end
    end

    // LED: feedback flash wins, otherwise the view value in view mode, else dark.
    always_comb begin
        led = '0;
        if (state == FLASH) begin
            led = '1;
        end else if (mode) begin
            led = view_q;
        end
    end

    assign ready         = (state == ARMED);
    assign vote_accepted = (state == COMMIT);
    assign vote_cand     = vote_accepted ? cand_idx : '0;

    vote_leader_tree #(
        .NUM_CAND (NUM_CAND),
        .CNT_W    (CNT_W)
    ) u_leader (
        .clock        (clock),
        .reset        (reset),
        .tallies      (tally_flat),
        .leader       (leader),
        .leader_valid (leader_valid)
    );

endmodule

// File: tb/tb_vote_tally_engine.sv
// tb/tb_vote_tally_engine.sv - scoreboard bench for vote_tally_engine
module tb_vote_tally_engine;

    localparam int NUM_CAND = 4;
    localparam int CNT_W    = 8;
    localparam int HOLD     = 10;
    localparam int FLASH    = 10;
    localparam int IDX_W    = 2;
    localparam int TMAX     = (1 << CNT_W) - 1;

    logic                clock = 1'b0;
    logic                reset;
    logic                mode;
    logic                session_start;
    logic [NUM_CAND-1:0] button;
    logic [IDX_W-1:0]    view_sel;
    logic [CNT_W-1:0]    led;
    logic                ready;
    logic                vote_accepted;
    logic [IDX_W-1:0]    vote_cand;
    logic [IDX_W-1:0]    leader;
    logic                leader_valid;
    logic [NUM_CAND-1:0] sat;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    int exp_q[$];
    int model_tally[NUM_CAND];
    bit model_sat[NUM_CAND];

    always #5 clock = ~clock;

    vote_tally_engine #(
        .NUM_CAND     (NUM_CAND),
        .CNT_W        (CNT_W),
        .HOLD_CYCLES  (HOLD),
        .FLASH_CYCLES (FLASH)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .mode          (mode),
        .session_start (session_start),
        .button        (button),
        .view_sel      (view_sel),
        .led           (led),
        .ready         (ready),
        .vote_accepted (vote_accepted),
        .vote_cand     (vote_cand),
        .leader        (leader),
        .leader_valid  (leader_valid),
        .sat           (sat)
    );

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted vote must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && vote_accepted) begin
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_vote: vote_cand=%0d with no vote expected at %0t", vote_cand, $time);
            end else begin
                check("vote_cand", vote_cand, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mode = 1'b0;
        session_start = 1'b0;
        button = '0;
        view_sel = '0;
        cyc(3);
        check("rst_led", led, 0);
        check("rst_ready", ready, 0);
        check("rst_accept", vote_accepted, 0);
        check("rst_cand", vote_cand, 0);
        check("rst_leader", leader, 0);
        check("rst_leader_valid", leader_valid, 0);
        check("rst_sat", sat, 0);
        reset = 1'b0;
        for (int i = 0; i < NUM_CAND; i++) begin
            model_tally[i] = 0;
            model_sat[i] = 1'b0;
        end
        exp_q.delete();
        pulses = 0;
        cyc(1);
    endtask

    task automatic start_session();
        session_start = 1'b1;
        cyc(1);
        session_start = 1'b0;
    endtask

    task automatic press(input logic [NUM_CAND-1:0] b, input int n);
        button = b;
        cyc(n);
        button = '0;
    endtask

    // Reference: one committed vote, saturating at full scale.
    task automatic expect_vote(input int c);
        exp_q.push_back(c);
        if (model_tally[c] >= TMAX) model_sat[c] = 1'b1;
        else model_tally[c] = model_tally[c] + 1;
    endtask

    task automatic vote(input int c);
        start_session();
        expect_vote(c);
        press(NUM_CAND'(1) << c, HOLD);
        cyc(FLASH + 4);
    endtask

    task automatic model_leader(output int li, output int lv);
        int best;
        int cnt;
        best = -1;
        cnt = 0;
        li = 0;
        for (int i = 0; i < NUM_CAND; i++)
            if (model_tally[i] > best) begin best = model_tally[i]; li = i; end
        for (int i = 0; i < NUM_CAND; i++)
            if (model_tally[i] == best) cnt++;
        lv = (cnt == 1) ? 1 : 0;
    endtask

    task automatic check_view();
        int li;
        int lv;
        logic [NUM_CAND-1:0] sv;
        mode = 1'b1;
        for (int i = 0; i < NUM_CAND; i++) begin
            view_sel = IDX_W'(i);
            cyc(1);
            check($sformatf("tally%0d", i), led, model_tally[i]);
        end
        for (int i = 0; i < NUM_CAND; i++) sv[i] = model_sat[i];
        check("sat", sat, sv);
        model_leader(li, lv);
        check("leader", leader, li);
        check("leader_valid", leader_valid, lv);
        mode = 1'b0;
        cyc(1);
    endtask

    task automatic rand_session();
        int c;
        int nf;
        int len;
        int oc;
        logic [NUM_CAND-1:0] p;
        c = $urandom_range(0, NUM_CAND - 1);
        start_session();
        nf = $urandom_range(0, 2);
        for (int k = 0; k < nf; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                oc = $urandom_range(0, NUM_CAND - 1);
                len = $urandom_range(1, HOLD - 1);
                press(NUM_CAND'(1) << oc, len);
            end else begin
                p = NUM_CAND'($urandom_range(0, (1 << NUM_CAND) - 1));
                while ($countones(p) < 2) p = NUM_CAND'($urandom_range(0, (1 << NUM_CAND) - 1));
                len = $urandom_range(1, 15);
                press(p, len);
            end
            cyc(1);
            check("rand_still_armed", ready, 1);
        end
        expect_vote(c);
        press(NUM_CAND'(1) << c, HOLD);
        cyc(FLASH + 4);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int ffcnt;
        do_reset();

        // Single vote for candidate 1 with a full-length flash.
        start_session();
        check("armed_ready", ready, 1);
        expect_vote(1);
        button = 4'b0010;
        cyc(HOLD);
        check("commit_pulse", vote_accepted, 1);
        button = '0;
        ffcnt = 0;
        for (int i = 0; i < FLASH + 4; i++) begin
            cyc(1);
            if (led == 8'hFF) ffcnt++;
        end
        check("flash_len", ffcnt, FLASH);
        check("ready_after", ready, 0);
        check("pulses_t1", pulses, 1);
        check_view();

        // Short press (one short of the threshold) then a full press.
        start_session();
        press(4'b0010, HOLD - 1);
        cyc(1);
        check("short_ready", ready, 1);
        check("short_pulses", pulses, 1);
        expect_vote(1);
        press(4'b0010, HOLD);
        cyc(FLASH + 4);
        check("pulses_t2", pulses, 2);

        // Two buttons at once is ignored, then a clean single press.
        start_session();
        button = 4'b0011;
        cyc(20);
        check("multi_ready", ready, 1);
        check("multi_pulses", pulses, 2);
        expect_vote(0);
        button = 4'b0001;
        cyc(HOLD);
        button = '0;
        cyc(FLASH + 4);
        check("pulses_t3", pulses, 3);

        // Button held well past the commit never yields a second vote.
        start_session();
        expect_vote(2);
        button = 4'b0100;
        cyc(HOLD + 50);
        check("held_ready", ready, 0);
        button = '0;
        cyc(3);
        check("pulses_t4", pulses, 4);
        check_view();

        // Saturation at full scale.
        do_reset();
        for (int k = 0; k < TMAX + 1; k++) begin
            vote(2);
            if (k == TMAX - 1) check("sat_not_yet", sat, 0);
        end
        check("sat_pulses", pulses, TMAX + 1);
        check_view();

        // Tie detection and leader latency.
        do_reset();
        for (int k = 0; k < 3; k++) vote(0);
        for (int k = 0; k < 5; k++) vote(1);
        for (int k = 0; k < 5; k++) vote(2);
        vote(3);
        check_view();
        start_session();
        expect_vote(2);
        button = 4'b0100;
        for (int i = 0; i < 3 * HOLD && !vote_accepted; i++) cyc(1);
        check("lat_vote_seen", vote_accepted, 1);
        button = '0;
        cyc(1);
        check("lat_old_valid", leader_valid, 0);
        check("lat_old_leader", leader, 1);
        cyc(1);
        check("lat_new_leader", leader, 2);
        check("lat_new_valid", leader_valid, 1);
        cyc(FLASH + 3);
        mode = 1'b1;
        view_sel = 2'd2;
        cyc(1);
        check("view2_led", led, 6);
        mode = 1'b0;
        cyc(1);

        // View mode during HOLD abandons the session.
        start_session();
        button = 4'b0001;
        cyc(5);
        mode = 1'b1;
        cyc(1);
        check("abort_ready", ready, 0);
        cyc(20);
        button = '0;
        mode = 1'b0;
        cyc(2);
        button = 4'b0001;
        cyc(HOLD + 5);
        check("abort_idle_ready", ready, 0);
        button = '0;
        cyc(2);
        check_view();

        // Randomized sessions with rejected attempts mixed in.
        for (int k = 0; k < 20; k++) rand_session();
        check_view();
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
